// File: rtl/fpu_result_router.sv
// fpu_result_router: return-side router for the two-thread shared FPU.
// Shadows the FPU pipe (E1..WB) with thread tags and steers writeback.
//
// Ports:
//   clk, clrn            clock, synchronous active-low reset
//   e                    pipeline advance (0 = FPU frozen, shadow holds)
//   iss_v/t/wf/fd        op entering E1 at this edge
//   ww, wn, wd           FPU writeback from the WB stage
//   ww0/wn0/wd0          thread 0 FP regfile write port
//   ww1/wn1/wd1          thread 1 FP regfile write port
//   pend0, pend1         ops of each thread inside the shadow pipe
//   busy0, busy1         per-register pending-write masks
//   err                  sticky protocol error
//
// Build option: define FPU_RR_CHECK_EN to enable the protocol checker.
// Without it err is tied to 0 and no check logic is built.
module fpu_result_router #(
    parameter int DEPTH = 4,
    parameter int FDW   = 5,
    parameter int DW    = 32
) (
    input  logic                         clk,
    input  logic                         clrn,
    input  logic                         e,
    input  logic                         iss_v,
    input  logic                         iss_t,
    input  logic                         iss_wf,
    input  logic [FDW-1:0]               iss_fd,
    input  logic                         ww,
    input  logic [FDW-1:0]               wn,
    input  logic [DW-1:0]                wd,
    output logic                         ww0,
    output logic                         ww1,
    output logic [FDW-1:0]               wn0,
    output logic [FDW-1:0]               wn1,
    output logic [DW-1:0]                wd0,
    output logic [DW-1:0]                wd1,
    output logic [$clog2(DEPTH+1)-1:0]   pend0,
    output logic [$clog2(DEPTH+1)-1:0]   pend1,
    output logic [2**FDW-1:0]            busy0,
    output logic [2**FDW-1:0]            busy1,
    output logic                         err
);

    localparam int PW = $clog2(DEPTH+1);
    localparam int WB = DEPTH - 1;
    localparam logic [PW-1:0] PMAX = PW'(DEPTH);

    // Shadow pipe, index 0 = E1 .. WB = DEPTH-1
    logic [DEPTH-1:0] sv;
    logic [DEPTH-1:0] st;
    logic [DEPTH-1:0] swf;
    logic [FDW-1:0]   sfd [DEPTH];

    always_ff @(posedge clk) begin
        if (!clrn) begin
            sv  <= '0;
            st  <= '0;
            swf <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                sfd[k] <= '0;
            end
        end else if (e) begin
            sv  <= {sv[DEPTH-2:0], iss_v};
            st  <= {st[DEPTH-2:0], iss_t};
            swf <= {swf[DEPTH-2:0], iss_wf};
            for (int k = DEPTH - 1; k > 0; k--) begin
                sfd[k] <= sfd[k-1];
            end
            sfd[0] <= iss_fd;
        end
    end

    logic wb_v;
    logic wb_t;
    logic wb_wf;

    assign wb_v  = sv[WB];
    assign wb_t  = st[WB];
    assign wb_wf = swf[WB];

    // Only a live, writing op in WB may reach a register file
    assign ww0 = ww & wb_v & wb_wf & ~wb_t;
    assign ww1 = ww & wb_v & wb_wf &  wb_t;
    assign wn0 = ww0 ? wn : '0;
    assign wn1 = ww1 ? wn : '0;
    assign wd0 = ww0 ? wd : '0;
    assign wd1 = ww1 ? wd : '0;

    // Pending-op counters
    logic inc0;
    logic inc1;
    logic dec0;
    logic dec1;

    assign inc0 = e & iss_v & ~iss_t;
    assign inc1 = e & iss_v &  iss_t;
    assign dec0 = e & wb_v  & ~wb_t;
    assign dec1 = e & wb_v  &  wb_t;

    // Issue and retire on the same edge cancel out; saturate at both ends
    always_ff @(posedge clk) begin
        if (!clrn) begin
            pend0 <= '0;
        end else if (inc0 & ~dec0 & (pend0 != PMAX)) begin
            pend0 <= pend0 + PW'(1);
        end else if (dec0 & ~inc0 & (pend0 != '0)) begin
            pend0 <= pend0 - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            pend1 <= '0;
        end else if (inc1 & ~dec1 & (pend1 != PMAX)) begin
            pend1 <= pend1 + PW'(1);
        end else if (dec1 & ~inc1 & (pend1 != '0)) begin
            pend1 <= pend1 - PW'(1);
        end
    end

    // A register stays busy while any stage still owes it a write
    always_comb begin
        busy0 = '0;
        busy1 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (sv[k] & swf[k]) begin
                if (st[k]) begin
                    busy1[sfd[k]] = 1'b1;
                end else begin
                    busy0[sfd[k]] = 1'b1;
                end
            end
        end
    end

`ifdef FPU_RR_CHECK_EN
    logic wr_bad;
    logic cnt_bad;

    // Write with nothing to own it, or to a register other than the tag
    assign wr_bad = ww & (~wb_v | ~wb_wf | (wn != sfd[WB]));

    assign cnt_bad = (inc0 & ~dec0 & (pend0 == PMAX))
                   | (dec0 & ~inc0 & (pend0 == '0))
                   | (inc1 & ~dec1 & (pend1 == PMAX))
                   | (dec1 & ~inc1 & (pend1 == '0));

    always_ff @(posedge clk) begin
        if (!clrn) begin
            err <= 1'b0;
        end else if (wr_bad | cnt_bad) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_result_router.sv
// tb_fpu_result_router: scoreboard bench for fpu_result_router.
// Bench models the FPU side and checks routed writebacks per thread.
module tb_fpu_result_router;

    localparam int DEPTH = 4;
    localparam int FDW   = 5;
    localparam int DW    = 32;
    localparam int PW    = $clog2(DEPTH+1);
    localparam int NR    = 2**FDW;

`ifdef FPU_RR_CHECK_EN
    localparam bit EXP_ERR = 1'b1;
`else
    localparam bit EXP_ERR = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           clrn;
    logic           e;
    logic           iss_v;
    logic           iss_t;
    logic           iss_wf;
    logic [FDW-1:0] iss_fd;
    logic           ww;
    logic [FDW-1:0] wn;
    logic [DW-1:0]  wd;
    logic           ww0;
    logic           ww1;
    logic [FDW-1:0] wn0;
    logic [FDW-1:0] wn1;
    logic [DW-1:0]  wd0;
    logic [DW-1:0]  wd1;
    logic [PW-1:0]  pend0;
    logic [PW-1:0]  pend1;
    logic [NR-1:0]  busy0;
    logic [NR-1:0]  busy1;
    logic           err;

    always #5 clk = ~clk;

    fpu_result_router #(.DEPTH(DEPTH), .FDW(FDW), .DW(DW)) dut (
        .clk(clk), .clrn(clrn), .e(e),
        .iss_v(iss_v), .iss_t(iss_t), .iss_wf(iss_wf), .iss_fd(iss_fd),
        .ww(ww), .wn(wn), .wd(wd),
        .ww0(ww0), .ww1(ww1), .wn0(wn0), .wn1(wn1),
        .wd0(wd0), .wd1(wd1),
        .pend0(pend0), .pend1(pend1),
        .busy0(busy0), .busy1(busy1), .err(err)
    );

    int checks = 0;
    int errors = 0;

    // FPU-side model: what the real FPU would present at WB
    bit             m_v  [DEPTH];
    bit             m_t  [DEPTH];
    bit             m_wf [DEPTH];
    logic [FDW-1:0] m_fd [DEPTH];
    logic [DW-1:0]  m_d  [DEPTH];
    int             m_uid[DEPTH];

    logic [DW-1:0]  iss_d;
    int             uid_ctr = 0;
    int             cur_uid = 0;
    int             last_uid = -1;

    bit             ovr_ww;
    logic [FDW-1:0] ovr_wn;
    logic [DW-1:0]  ovr_wd;

    typedef struct {
        bit             t;
        logic [FDW-1:0] fd;
        logic [DW-1:0]  d;
    } exp_t;

    exp_t exp_q[$];
    exp_t mx;
    bit             g_t;
    logic [FDW-1:0] g_fd;
    logic [DW-1:0]  g_d;

    task automatic tick();
        @(posedge clk);
        if (!clrn) begin
            for (int k = 0; k < DEPTH; k++) m_v[k] = 1'b0;
        end else if (e) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                m_v[k]   = m_v[k-1];
                m_t[k]   = m_t[k-1];
                m_wf[k]  = m_wf[k-1];
                m_fd[k]  = m_fd[k-1];
                m_d[k]   = m_d[k-1];
                m_uid[k] = m_uid[k-1];
            end
            m_v[0]   = iss_v;
            m_t[0]   = iss_t;
            m_wf[0]  = iss_wf;
            m_fd[0]  = iss_fd;
            m_d[0]   = iss_d;
            m_uid[0] = cur_uid;
        end
        #1;
        iss_v = 1'b0;
        ww = ovr_ww | (m_v[DEPTH-1] & m_wf[DEPTH-1]);
        wn = ovr_ww ? ovr_wn : m_fd[DEPTH-1];
        wd = ovr_ww ? ovr_wd : m_d[DEPTH-1];
        @(negedge clk);
    endtask

    task automatic issue(input bit t, input bit wf,
                         input logic [FDW-1:0] fd,
                         input logic [DW-1:0] d);
        iss_v  = 1'b1;
        iss_t  = t;
        iss_wf = wf;
        iss_fd = fd;
        iss_d  = d;
        uid_ctr++;
        cur_uid = uid_ctr;
        if (wf && e && clrn) exp_q.push_back('{t, fd, d});
        tick();
    endtask

    // Scoreboard: each new retiring write is popped once
    always @(negedge clk) begin
        if (ww0 || ww1) begin
            if (m_uid[DEPTH-1] != last_uid) begin
                last_uid = m_uid[DEPTH-1];
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected ww0=%0b ww1=%0b want no write",
                             ww0, ww1);
                end else begin
                    mx   = exp_q.pop_front();
                    g_t  = ww1;
                    g_fd = ww1 ? wn1 : wn0;
                    g_d  = ww1 ? wd1 : wd0;
                    if ((ww0 && ww1) || g_t != mx.t ||
                        g_fd !== mx.fd || g_d !== mx.d) begin
                        errors++;
                        $display("FAIL sb_write got t=%0b fd=%0d d=%h both=%0b want t=%0b fd=%0d d=%h",
                                 g_t, g_fd, g_d, ww0 && ww1, mx.t, mx.fd, mx.d);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        clrn = 1'b0; e = 1'b1;
        ovr_ww = 1'b1; ovr_wn = 5'd3; ovr_wd = 32'hDEADBEEF;
        ww = 1'b1; wn = 5'd3; wd = 32'hDEADBEEF;
        iss_v = 1'b1; iss_t = 1'b1; iss_wf = 1'b1; iss_fd = 5'd3;
        tick();
        checks++;
        if (ww0 !== 1'b0 || ww1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_ww ww0=%0b ww1=%0b want 0 0", ww0, ww1);
        end
        checks++;
        if (wn0 !== '0 || wn1 !== '0 || wd0 !== '0 || wd1 !== '0) begin
            errors++;
            $display("FAIL reset_wnwd wn0=%0d wn1=%0d wd0=%h wd1=%h want 0",
                     wn0, wn1, wd0, wd1);
        end
        checks++;
        if (pend0 !== '0 || pend1 !== '0) begin
            errors++;
            $display("FAIL reset_pend pend0=%0d pend1=%0d want 0 0", pend0, pend1);
        end
        checks++;
        if (busy0 !== '0 || busy1 !== '0) begin
            errors++;
            $display("FAIL reset_busy busy0=%h busy1=%h want 0 0", busy0, busy1);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err err=%0b want 0", err);
        end
        ovr_ww = 1'b0; ww = 1'b0;
        clrn = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [NR-1:0] eb;
        logic [PW-1:0] ep;
        bit            ew;
        issue(1'b1, 1'b1, 5'd7, 32'h3F800000);
        for (int i = 0; i <= 4; i++) begin
            if (i > 0) tick();
            ew = (i == 3);
            eb = (i <= 3) ? NR'(32'h80) : '0;
            ep = (i <= 3) ? PW'(1) : '0;
            checks++;
            if (ww1 !== ew || ww0 !== 1'b0 || busy1 !== eb ||
                pend1 !== ep || busy0 !== '0 || pend0 !== '0) begin
                errors++;
                $display("FAIL single_e%0d ww0=%0b ww1=%0b busy1=%h pend1=%0d want 0 %0b %h %0d",
                         i, ww0, ww1, busy1, pend1, ew, eb, ep);
            end
            if (i == 3) begin
                checks++;
                if (wd1 !== 32'h3F800000 || wn1 !== 5'd7 || wd0 !== '0) begin
                    errors++;
                    $display("FAIL single_data wd1=%h wn1=%0d wd0=%h want 3f800000 7 0",
                             wd1, wn1, wd0);
                end
            end
        end
    endtask

    task automatic test_freeze();
        issue(1'b1, 1'b1, 5'd7, 32'h40000000);
        tick();
        e = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                iss_v = 1'b1; iss_t = 1'b0; iss_wf = 1'b1; iss_fd = 5'd9;
            end
            tick();
            checks++;
            if (busy1 !== NR'(32'h80) || pend1 !== PW'(1) || ww1 !== 1'b0 ||
                pend0 !== '0 || busy0 !== '0) begin
                errors++;
                $display("FAIL freeze_c%0d busy1=%h pend1=%0d ww1=%0b pend0=%0d busy0=%h want 80 1 0 0 0",
                         i, busy1, pend1, ww1, pend0, busy0);
            end
        end
        e = 1'b1;
        tick();
        checks++;
        if (ww1 !== 1'b0) begin
            errors++;
            $display("FAIL freeze_early ww1=%0b want 0", ww1);
        end
        tick();
        checks++;
        if (ww1 !== 1'b1 || wd1 !== 32'h40000000) begin
            errors++;
            $display("FAIL freeze_wb ww1=%0b wd1=%h want 1 40000000", ww1, wd1);
        end
        tick();
        checks++;
        if (pend1 !== '0 || busy1 !== '0) begin
            errors++;
            $display("FAIL freeze_drain pend1=%0d busy1=%h want 0 0", pend1, busy1);
        end
    endtask

    task automatic test_back_to_back();
        logic [NR-1:0] b0;
        logic [NR-1:0] b1;
        bit            w0;
        bit            w1;
        for (int j = 0; j <= 5; j++) begin
            if (j == 0)      issue(1'b0, 1'b1, 5'd2, 32'h11111111);
            else if (j == 1) issue(1'b1, 1'b1, 5'd2, 32'h22222222);
            else             tick();
            b0 = (j <= 3) ? NR'(4) : '0;
            b1 = (j >= 1 && j <= 4) ? NR'(4) : '0;
            w0 = (j == 3);
            w1 = (j == 4);
            checks++;
            if (busy0 !== b0 || busy1 !== b1 || ww0 !== w0 || ww1 !== w1) begin
                errors++;
                $display("FAIL b2b_e%0d busy0=%h busy1=%h ww0=%0b ww1=%0b want %h %h %0b %0b",
                         j, busy0, busy1, ww0, ww1, b0, b1, w0, w1);
            end
        end
    endtask

    task automatic test_fill();
        int ep[12] = '{1, 2, 3, 4, 4, 4, 3, 2, 1, 0, 0, 0};
        bit wf[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int j = 0; j < 12; j++) begin
            if (j < 6) issue(1'b0, wf[j], FDW'(j + 1), DW'(32'hA000 + j));
            else       tick();
            checks++;
            if (pend0 !== PW'(ep[j]) || pend1 !== '0 || busy1 !== '0) begin
                errors++;
                $display("FAIL fill_e%0d pend0=%0d pend1=%0d busy1=%h want %0d 0 0",
                         j, pend0, pend1, busy1, ep[j]);
            end
            if (j == 3) begin
                checks++;
                if (busy0 !== NR'(32'h1A)) begin
                    errors++;
                    $display("FAIL fill_busy busy0=%h want 1a", busy0);
                end
            end
        end
    endtask

    task automatic test_stray_ww();
        ovr_ww = 1'b1; ovr_wn = 5'd5; ovr_wd = 32'hCAFE0000;
        tick();
        checks++;
        if (ww0 !== 1'b0 || ww1 !== 1'b0 || wd0 !== '0 || wd1 !== '0) begin
            errors++;
            $display("FAIL stray_ww ww0=%0b ww1=%0b wd0=%h wd1=%h want 0",
                     ww0, ww1, wd0, wd1);
        end
        ovr_ww = 1'b0;
        tick();
        tick();
        checks++;
        if (err !== EXP_ERR) begin
            errors++;
            $display("FAIL stray_err err=%0b want %0b", err, EXP_ERR);
        end
        issue(1'b1, 1'b0, 5'd4, 32'h0);
        tick();
        tick();
        ovr_ww = 1'b1; ovr_wn = 5'd4; ovr_wd = 32'h12345678;
        tick();
        checks++;
        if (ww1 !== 1'b0 || ww0 !== 1'b0 || pend1 !== PW'(1)) begin
            errors++;
            $display("FAIL nowf_ww ww0=%0b ww1=%0b pend1=%0d want 0 0 1",
                     ww0, ww1, pend1);
        end
        ovr_ww = 1'b0;
        tick();
        checks++;
        if (err !== EXP_ERR || pend1 !== '0) begin
            errors++;
            $display("FAIL sticky_err err=%0b pend1=%0d want %0b 0",
                     err, pend1, EXP_ERR);
        end
        clrn = 1'b0;
        tick();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear err=%0b want 0", err);
        end
        clrn = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired want finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < DEPTH; k++) begin
            m_fd[k] = '0;
            m_d[k]  = '0;
        end
        clrn = 1'b0; e = 1'b1;
        iss_v = 1'b0; iss_t = 1'b0; iss_wf = 1'b0; iss_fd = '0; iss_d = '0;
        ww = 1'b0; wn = '0; wd = '0;
        ovr_ww = 1'b0; ovr_wn = '0; ovr_wd = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_freeze();
        test_back_to_back();
        test_fill();
        test_stray_ww();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover left=%0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
